// File: rtl/population_evaluation_scheduler_pkg.sv
// Shared definitions for the population evaluation scheduler:
// default widths, the engine error-sum bundle and the FSM state encoding.
package population_evaluation_scheduler_pkg;

   localparam int CHROM_W_DEF = 992;  // chromosome description width
   localparam int IDX_W_DEF   = 8;    // chromosome index width (population up to 256)
   localparam int NUM_SUMS    = 8;    // engine outputs, one error sum each
   localparam int SUM_W       = 32;   // width of one error sum
   localparam int FIT_W_DEF   = 35;   // eight 32-bit sums need 3 extra bits

   // Per-output error sums reported by the processing engine
   typedef logic [NUM_SUMS-1:0][SUM_W-1:0] error_sums_t;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_FETCH      = 3'd1,
      S_LATCH      = 3'd2,
      S_WAIT_READY = 3'd3,
      S_START      = 3'd4,
      S_WAIT_DONE  = 3'd5,
      S_ACK        = 3'd6,
      S_DONE       = 3'd7
   } state_t;

endpackage

// File: rtl/population_evaluation_scheduler_fitness_adder.sv
// Fitness adder: folds the eight 32-bit engine error sums into one
// zero-extended fitness value. Purely combinational so it can also be
// shared with the host-side readback path.
module population_evaluation_scheduler_fitness_adder
   import population_evaluation_scheduler_pkg::*;
#(
   parameter int FIT_W = FIT_W_DEF
) (
   input  error_sums_t      i_sums,
   output logic [FIT_W-1:0] o_sum
);

   logic [FIT_W-1:0] w_ext [NUM_SUMS];

   // Zero-extend each error sum to the fitness width before adding
   generate
      for (genvar gi = 0; gi < NUM_SUMS; gi++) begin : g_ext
         assign w_ext[gi] = FIT_W'(i_sums[gi]);
      end
   endgenerate

   // Accumulate the extended sums; the extra bits absorb all carries
   always_comb begin
      o_sum = '0;
      for (int i = 0; i < NUM_SUMS; i++) begin
         o_sum = o_sum + w_ext[i];
      end
   end

endmodule

// File: rtl/population_evaluation_scheduler.sv
// Population evaluation scheduler: walks one generation of chromosomes
// through the single processing engine, computes each fitness, tracks the
// best individual and reports perfect-solution / timeout conditions.
// Every output is a register or a decode of the current state.
module population_evaluation_scheduler
   import population_evaluation_scheduler_pkg::*;
#(
   parameter int CHROM_W = CHROM_W_DEF,
   parameter int IDX_W   = IDX_W_DEF,
   parameter int FIT_W   = FIT_W_DEF
) (
   input  logic               iClock,
   input  logic               iReset,
   input  logic               iStartGeneration,
   input  logic [IDX_W:0]     iChromCount,
   input  logic               iStopOnPerfect,
   input  logic [31:0]        iTimeoutCycles,
   output logic               oBusy,
   output logic               oGenerationDone,
   output logic [IDX_W-1:0]   oChromIndex,
   input  logic [CHROM_W-1:0] iChromDescription,
   output logic [CHROM_W-1:0] oChromDescription,
   output logic               oStartProcessing,
   input  logic               iReadyToProcess,
   input  logic               iDoneProcessing,
   output logic               oDoneProcessingFeedback,
   input  error_sums_t        iErrorSums,
   output logic               oFitnessValid,
   output logic [FIT_W-1:0]   oFitness,
   output logic [IDX_W-1:0]   oFitnessIndex,
   output logic [FIT_W-1:0]   oBestFitness,
   output logic [IDX_W-1:0]   oBestIndex,
   output logic               oPerfectFound,
   output logic               oTimeoutError
);

   state_t             r_state;
   state_t             w_state_next;
   logic [IDX_W:0]     r_count;
   logic               r_stop;
   logic [IDX_W-1:0]   r_idx;
   logic [CHROM_W-1:0] r_desc;
   logic [FIT_W-1:0]   r_fitness;
   logic [IDX_W-1:0]   r_fit_idx;
   logic [FIT_W-1:0]   r_best;
   logic [IDX_W-1:0]   r_best_idx;
   logic               r_perfect;
   logic               r_timeout_err;
   logic [31:0]        r_timer;
   logic               r_drain_fb;

   logic [FIT_W-1:0]   w_sum;
   logic               w_last;
   logic               w_timeout_hit;
   logic               w_stop_now;

   population_evaluation_scheduler_fitness_adder #(
      .FIT_W (FIT_W)
   ) u_fitness_adder (
      .i_sums (iErrorSums),
      .o_sum  (w_sum)
   );

   assign w_last        = ({1'b0, r_idx} == (r_count - (IDX_W+1)'(1)));
   // Compared before incrementing, so the counter can never wrap
   assign w_timeout_hit = (iTimeoutCycles != 32'd0) && (r_timer == (iTimeoutCycles - 32'd1));
   assign w_stop_now    = ((r_fitness == '0) && r_stop) || w_last;

   // State register
   always_ff @(posedge iClock) begin
      if (iReset) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state logic and state-decoded outputs
   always_comb begin
      w_state_next            = r_state;
      oBusy                   = (r_state != S_IDLE);
      oGenerationDone         = (r_state == S_DONE);
      oStartProcessing        = (r_state == S_START);
      oFitnessValid           = (r_state == S_ACK);
      // Drain pulse is registered so no input reaches an output combinationally
      oDoneProcessingFeedback = (r_state == S_ACK) || r_drain_fb;
      case (r_state)
         S_IDLE: begin
            if (iStartGeneration)
               w_state_next = (iChromCount == '0) ? S_DONE : S_FETCH;
         end
         S_FETCH:      w_state_next = S_LATCH;
         S_LATCH:      w_state_next = S_WAIT_READY;
         S_WAIT_READY: begin
            // While a drain pulse is out, the engine still shows done; wait it out
            if (!r_drain_fb && !iDoneProcessing && iReadyToProcess)
               w_state_next = S_START;
         end
         S_START:      w_state_next = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (iDoneProcessing)    w_state_next = S_ACK;
            else if (w_timeout_hit) w_state_next = S_DONE;
         end
         S_ACK:        w_state_next = w_stop_now ? S_DONE : S_FETCH;
         S_DONE:       w_state_next = S_IDLE;
         default:      w_state_next = S_IDLE;
      endcase
   end

   // Datapath: generation bookkeeping, description latch, fitness and best tracking
   always_ff @(posedge iClock) begin
      if (iReset) begin
         r_count       <= '0;
         r_stop        <= 1'b0;
         r_idx         <= '0;
         r_desc        <= '0;
         r_fitness     <= '0;
         r_fit_idx     <= '0;
         r_best        <= '1;
         r_best_idx    <= '0;
         r_perfect     <= 1'b0;
         r_timeout_err <= 1'b0;
         r_timer       <= '0;
         r_drain_fb    <= 1'b0;
      end else begin
         r_drain_fb <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (iStartGeneration) begin
                  r_count       <= iChromCount;
                  r_stop        <= iStopOnPerfect;
                  r_idx         <= '0;
                  r_best        <= '1;
                  r_best_idx    <= '0;
                  r_perfect     <= 1'b0;
                  r_timeout_err <= 1'b0;
               end
            end
            S_LATCH: r_desc <= iChromDescription;
            S_WAIT_READY: begin
               // Stale done left by a previous generation or reset: release it
               if (!r_drain_fb && iDoneProcessing) r_drain_fb <= 1'b1;
            end
            S_START: r_timer <= '0;
            S_WAIT_DONE: begin
               if (iDoneProcessing) begin
                  r_fitness <= w_sum;
                  r_fit_idx <= r_idx;
               end else if (w_timeout_hit) begin
                  r_timeout_err <= 1'b1;
               end else begin
                  r_timer <= r_timer + 32'd1;
               end
            end
            S_ACK: begin
               // Strict compare keeps the lower index on ties
               if (r_fitness < r_best) begin
                  r_best     <= r_fitness;
                  r_best_idx <= r_fit_idx;
               end
               if (r_fitness == '0) r_perfect <= 1'b1;
               if (!w_stop_now)     r_idx     <= r_idx + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign oChromIndex       = r_idx;
   assign oChromDescription = r_desc;
   assign oFitness          = r_fitness;
   assign oFitnessIndex     = r_fit_idx;
   assign oBestFitness      = r_best;
   assign oBestIndex        = r_best_idx;
   assign oPerfectFound     = r_perfect;
   assign oTimeoutError     = r_timeout_err;

endmodule

// File: tb/tb_population_evaluation_scheduler.sv
// Directed bench for population_evaluation_scheduler with a RAM model,
// a behavioural engine model and a scoreboard of expected fitness results.
module tb_population_evaluation_scheduler;

   localparam int CW = 992;
   localparam int IW = 8;
   localparam int FW = 35;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst, start, stop;
   logic [IW:0]          count;
   logic [31:0]          tmo;
   logic                 busy, gen_done, start_proc, done_fb, fit_valid, perfect, tmo_err;
   logic [IW-1:0]        chrom_idx, fit_idx, best_idx;
   logic [CW-1:0]        desc_out;
   logic [FW-1:0]        fitness, best_fit;
   logic [7:0][31:0]     err_sums;

   logic [CW-1:0]        mem [256];
   logic [CW-1:0]        ram_q;
   logic [7:0][31:0]     sums_tab [256];

   logic                 eng_rst, eng_ready, eng_done, eng_hang;
   int                   eng_lat, eng_cnt;
   logic [7:0]           eng_sel;

   typedef struct { int idx; logic [63:0] fit; } exp_t;
   exp_t sb[$];

   int n_tests = 0;
   int n_fail  = 0;

   population_evaluation_scheduler dut (
      .iClock                  (clk),
      .iReset                  (rst),
      .iStartGeneration        (start),
      .iChromCount             (count),
      .iStopOnPerfect          (stop),
      .iTimeoutCycles          (tmo),
      .oBusy                   (busy),
      .oGenerationDone         (gen_done),
      .oChromIndex             (chrom_idx),
      .iChromDescription       (ram_q),
      .oChromDescription       (desc_out),
      .oStartProcessing        (start_proc),
      .iReadyToProcess         (eng_ready),
      .iDoneProcessing         (eng_done),
      .oDoneProcessingFeedback (done_fb),
      .iErrorSums              (err_sums),
      .oFitnessValid           (fit_valid),
      .oFitness                (fitness),
      .oFitnessIndex           (fit_idx),
      .oBestFitness            (best_fit),
      .oBestIndex              (best_idx),
      .oPerfectFound           (perfect),
      .oTimeoutError           (tmo_err)
   );

   // Population RAM with registered read
   always @(posedge clk) ram_q <= mem[chrom_idx];

   assign err_sums = sums_tab[eng_sel];

   // Engine model: ready -> busy (eng_lat cycles) -> done held until feedback
   always @(posedge clk) begin
      if (eng_rst) begin
         eng_ready <= 1'b1; eng_done <= 1'b0; eng_cnt <= 0; eng_sel <= '0;
      end else if (eng_ready) begin
         if (start_proc) begin
            eng_ready <= 1'b0; eng_cnt <= eng_lat; eng_sel <= desc_out[7:0];
         end
      end else if (eng_done) begin
         if (done_fb) begin eng_done <= 1'b0; eng_ready <= 1'b1; end
      end else if (!eng_hang) begin
         if (eng_cnt == 0) eng_done <= 1'b1;
         else              eng_cnt  <= eng_cnt - 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_busy"},      64'(busy),      64'd0);
      chk({tag, "_idx"},       64'(chrom_idx), 64'd0);
      chk({tag, "_desc_zero"}, 64'(desc_out == '0), 64'd1);
      chk({tag, "_fitness"},   64'(fitness),   64'd0);
      chk({tag, "_fit_idx"},   64'(fit_idx),   64'd0);
      chk({tag, "_best"},      64'(best_fit),  64'h7_FFFF_FFFF);
      chk({tag, "_best_idx"},  64'(best_idx),  64'd0);
      chk({tag, "_perfect"},   64'(perfect),   64'd0);
      chk({tag, "_timeout"},   64'(tmo_err),   64'd0);
      chk({tag, "_pulses"},    64'({gen_done, start_proc, fit_valid}), 64'd0);
   endtask

   task automatic push(input int idx, input logic [63:0] fit);
      exp_t e;
      e.idx = idx; e.fit = fit;
      sb.push_back(e);
   endtask

   // Start a generation and observe it until the done pulse (bounded)
   task automatic run_gen(input int cnt, input bit stp, input int tmo_c, input int restart_at,
                          input int budget, output int n_valid, output int n_fb, output int n_start,
                          output int fb_first, output int cyc_start, output int cyc_done,
                          output int max_idx);
      int cyc;
      bit got_done;
      exp_t e;
      n_valid = 0; n_fb = 0; n_start = 0; fb_first = 0;
      cyc_start = -1; cyc_done = -1; max_idx = 0;
      count = 9'(cnt); stop = stp; tmo = 32'(tmo_c); start = 1'b1;
      cyc = 0; got_done = 0;
      while (!got_done && cyc < budget) begin
         @(negedge clk);
         cyc++;
         start = (cyc == restart_at);
         if (cyc == restart_at) count = 9'd9;
         if (busy && int'(chrom_idx) > max_idx) max_idx = int'(chrom_idx);
         if (done_fb) begin n_fb++; if (n_start == 0) fb_first++; end
         if (start_proc) begin if (n_start == 0) cyc_start = cyc; n_start++; end
         if (fit_valid) begin
            n_valid++;
            if (sb.size() == 0) begin
               n_tests++; n_fail++;
               $error("FAIL sb_unexpected_valid: observed index %0d fitness %0h expected no result",
                      fit_idx, fitness);
            end else begin
               e = sb.pop_front();
               chk("fit_index", 64'(fit_idx), 64'(e.idx));
               chk("fitness", 64'(fitness), e.fit);
               n_tests++;
               assert (desc_out === mem[e.idx]) else begin
                  n_fail++;
                  $error("FAIL desc_held: observed %0h expected %0h", desc_out[31:0], mem[e.idx][31:0]);
               end
            end
         end
         if (gen_done) begin got_done = 1; cyc_done = cyc; end
      end
      start = 1'b0;
      $display("[TB] generation count=%0d: valid=%0d fb=%0d starts=%0d done_cycle=%0d best=%0h@%0d",
               cnt, n_valid, n_fb, n_start, cyc_done, best_fit, best_idx);
      chk("gen_done_seen", 64'(got_done), 64'd1);
      chk("sb_drained", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int nv, nf, ns, ff, cs, cd, mi;
      bit seen;

      rst = 1'b1; start = 1'b0; count = '0; stop = 1'b0; tmo = '0;
      eng_rst = 1'b1; eng_hang = 1'b0; eng_lat = 3;
      for (int i = 0; i < 256; i++) begin
         sums_tab[i] = '0;
         for (int w = 0; w < 31; w++) mem[i][w*32 +: 32] = {16'hC3A5, 8'(w), 8'(i)};
      end
      repeat (3) @(negedge clk);
      eng_rst = 1'b0; rst = 1'b0;
      @(negedge clk);
      chk_reset_values("por");

      // Count 3: fitness 3, 5, 0 -> best 0 at index 2
      sums_tab[0][0] = 32'd1; sums_tab[0][7] = 32'd2;
      sums_tab[1][0] = 32'd5;
      push(0, 64'd3); push(1, 64'd5); push(2, 64'd0);
      run_gen(3, 0, 0, 0, 500, nv, nf, ns, ff, cs, cd, mi);
      chk("g1_valid", 64'(nv), 64'd3);
      chk("g1_fb", 64'(nf), 64'd3);
      chk("g1_starts", 64'(ns), 64'd3);
      chk("g1_best", 64'(best_fit), 64'd0);
      chk("g1_best_idx", 64'(best_idx), 64'd2);
      chk("g1_perfect", 64'(perfect), 64'd1);
      @(negedge clk);
      chk("g1_idle", 64'(busy), 64'd0);

      // Count 4 with stop-on-perfect: chromosome 1 is perfect, 2 is never fetched
      for (int i = 0; i < 4; i++) sums_tab[i] = '0;
      sums_tab[0][3] = 32'd9; sums_tab[2][0] = 32'd4; sums_tab[3][0] = 32'd4;
      eng_lat = 0;
      push(0, 64'd9); push(1, 64'd0);
      run_gen(4, 1, 0, 0, 500, nv, nf, ns, ff, cs, cd, mi);
      chk("g2_valid", 64'(nv), 64'd2);
      chk("g2_perfect", 64'(perfect), 64'd1);
      chk("g2_max_idx", 64'(mi), 64'd1);
      chk("g2_best_idx", 64'(best_idx), 64'd1);
      @(negedge clk);

      // Tie 7,7 keeps index 0; full-scale sums exercise the 35-bit width
      for (int i = 0; i < 4; i++) sums_tab[i] = '0;
      sums_tab[0][0] = 32'd3; sums_tab[0][1] = 32'd4;
      sums_tab[1][5] = 32'd7;
      for (int k = 0; k < 8; k++) sums_tab[2][k] = 32'hFFFF_FFFF;
      eng_lat = 5;
      push(0, 64'd7); push(1, 64'd7); push(2, 64'h7_FFFF_FFF8);
      run_gen(3, 0, 0, 0, 500, nv, nf, ns, ff, cs, cd, mi);
      chk("g3_best", 64'(best_fit), 64'd7);
      chk("g3_best_idx", 64'(best_idx), 64'd0);
      chk("g3_perfect_cleared", 64'(perfect), 64'd0);
      @(negedge clk);

      // Count 0: immediate done, no engine start, best stays all-ones
      run_gen(0, 0, 0, 0, 20, nv, nf, ns, ff, cs, cd, mi);
      chk("g4_done_latency", 64'(cd), 64'd1);
      chk("g4_starts", 64'(ns), 64'd0);
      chk("g4_best", 64'(best_fit), 64'h7_FFFF_FFFF);
      chk("g4_best_idx", 64'(best_idx), 64'd0);
      @(negedge clk);

      // Timeout 50 with a hung engine
      eng_hang = 1'b1;
      run_gen(2, 0, 50, 0, 500, nv, nf, ns, ff, cs, cd, mi);
      chk("g5_timeout_latency", 64'(cd - cs), 64'd51);
      chk("g5_timeout_flag", 64'(tmo_err), 64'd1);
      chk("g5_valid", 64'(nv), 64'd0);
      eng_hang = 1'b0;
      repeat (10) @(negedge clk);
      // Next generation must release the stale done before starting
      sums_tab[0] = '0; sums_tab[0][2] = 32'd11;
      push(0, 64'd11);
      run_gen(1, 0, 0, 0, 500, nv, nf, ns, ff, cs, cd, mi);
      chk("g6_drain_first", 64'(ff), 64'd1);
      chk("g6_fb", 64'(nf), 64'd2);
      chk("g6_timeout_cleared", 64'(tmo_err), 64'd0);
      chk("g6_best", 64'(best_fit), 64'd11);
      @(negedge clk);

      // Reset during WAIT_DONE aborts without a done pulse
      eng_lat = 30;
      count = 9'd3; stop = 1'b0; tmo = '0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 0;
      for (int c = 0; c < 50 && !seen; c++) begin
         if (start_proc) seen = 1;
         else @(negedge clk);
      end
      chk("g7_started", 64'(seen), 64'd1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_values("midrst");
      // Restart: stale engine completion is drained; a start pulse while busy is ignored
      sums_tab[0] = '0; sums_tab[0][1] = 32'd4;
      sums_tab[1] = '0; sums_tab[1][6] = 32'd6;
      push(0, 64'd4); push(1, 64'd6);
      run_gen(2, 0, 0, 5, 800, nv, nf, ns, ff, cs, cd, mi);
      chk("g8_valid", 64'(nv), 64'd2);
      chk("g8_fb", 64'(nf), 64'd3);
      chk("g8_drain_first", 64'(ff), 64'd1);
      chk("g8_best", 64'(best_fit), 64'd4);
      chk("g8_best_idx", 64'(best_idx), 64'd0);
      @(negedge clk);
      chk("g8_idle", 64'(busy), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
